// File: rtl/urng_pkg.sv
// Shared widths, taus88 constants and helper functions for the uniform RNG.
package urng_pkg;

  localparam int unsigned TAUS_W  = 32;
  localparam int unsigned U0_W    = 48;
  localparam int unsigned U1_W    = 16;
  localparam int unsigned STATE_W = 3 * TAUS_W;
  localparam int unsigned SEED_W  = 2 * STATE_W;

  localparam logic [TAUS_W-1:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [TAUS_W-1:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [TAUS_W-1:0] MASK2 = 32'hFFFF_FFF0;

  // Per component: left shift of masked state, feedback shift, right shift
  localparam int unsigned S0_A = 12;
  localparam int unsigned S0_B = 13;
  localparam int unsigned S0_C = 19;
  localparam int unsigned S1_A = 4;
  localparam int unsigned S1_B = 2;
  localparam int unsigned S1_C = 25;
  localparam int unsigned S2_A = 17;
  localparam int unsigned S2_B = 3;
  localparam int unsigned S2_C = 11;

  localparam logic [TAUS_W-1:0] SEED_DEF_A = 32'd12345;
  localparam logic [TAUS_W-1:0] SEED_DEF_B = 32'd987654321;

  typedef struct packed {
    logic [TAUS_W-1:0] s0;
    logic [TAUS_W-1:0] s1;
    logic [TAUS_W-1:0] s2;
  } taus_state_t;

  function automatic taus_state_t taus88_step(input taus_state_t s);
    taus_state_t n;
    n.s0 = ((s.s0 & MASK0) << S0_A) ^ (((s.s0 << S0_B) ^ s.s0) >> S0_C);
    n.s1 = ((s.s1 & MASK1) << S1_A) ^ (((s.s1 << S1_B) ^ s.s1) >> S1_C);
    n.s2 = ((s.s2 & MASK2) << S2_A) ^ (((s.s2 << S2_B) ^ s.s2) >> S2_C);
    return n;
  endfunction

  // Small seeds would leave a component stuck in its all-zero orbit
  function automatic taus_state_t taus88_fixup(input taus_state_t s);
    taus_state_t f;
    f = s;
    if (s.s0 < 32'd2)  f.s0[1] = 1'b1;
    if (s.s1 < 32'd8)  f.s1[3] = 1'b1;
    if (s.s2 < 32'd16) f.s2[4] = 1'b1;
    return f;
  endfunction

  function automatic logic [TAUS_W-1:0] taus88_word(input taus_state_t s);
    return s.s0 ^ s.s1 ^ s.s2;
  endfunction

endpackage

// File: rtl/taus88_core.sv
// One combined Tausworthe generator: 96-bit state with load/step/hold and seed fix-up.
module taus88_core
  import urng_pkg::*;
#(
  parameter logic [STATE_W-1:0] SEED = {SEED_DEF_A, SEED_DEF_A, SEED_DEF_A}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [STATE_W-1:0] seed_in,
  output logic [TAUS_W-1:0]  word_c
);

  taus_state_t state;
  taus_state_t state_next;

  assign state_next = taus88_step(state);
  assign word_c     = taus88_word(state_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= taus88_fixup(SEED);
    end else if (load) begin
      state <= taus88_fixup(seed_in);
    end else if (step) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/taus_urng.sv
// Uniform random source: two taus88 generators behind a valid/ready output register.
// Optional build macro URNG_ZERO_SKIP_EN suppresses all-zero u0 candidates.
module taus_urng
  import urng_pkg::*;
#(
  parameter logic [TAUS_W-1:0] SEED_A0 = SEED_DEF_A,
  parameter logic [TAUS_W-1:0] SEED_A1 = SEED_DEF_A,
  parameter logic [TAUS_W-1:0] SEED_A2 = SEED_DEF_A,
  parameter logic [TAUS_W-1:0] SEED_B0 = SEED_DEF_B,
  parameter logic [TAUS_W-1:0] SEED_B1 = SEED_DEF_B,
  parameter logic [TAUS_W-1:0] SEED_B2 = SEED_DEF_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_ld,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [U0_W-1:0]   u0,
  output logic [U1_W-1:0]   u1,
  output logic [31:0]       sample_cnt
);

  logic              adv;
  logic              gen_step;
  logic              cand_ok;
  logic [TAUS_W-1:0] word_a;
  logic [TAUS_W-1:0] word_b;
  logic [U0_W-1:0]   cand_u0;
  logic [U1_W-1:0]   cand_u1;

  assign adv      = !out_valid || out_ready;
  assign gen_step = adv && !seed_ld;
  assign cand_u0  = {word_a, word_b[TAUS_W-1:U1_W]};
  assign cand_u1  = word_b[U1_W-1:0];

`ifdef URNG_ZERO_SKIP_EN
  assign cand_ok = |cand_u0;
`else
  assign cand_ok = 1'b1;
`endif

  taus88_core #(
    .SEED({SEED_A0, SEED_A1, SEED_A2})
  ) u_core_a (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_ld),
    .step    (gen_step),
    .seed_in (seed_in[SEED_W-1:STATE_W]),
    .word_c  (word_a)
  );

  taus88_core #(
    .SEED({SEED_B0, SEED_B1, SEED_B2})
  ) u_core_b (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_ld),
    .step    (gen_step),
    .seed_in (seed_in[STATE_W-1:0]),
    .word_c  (word_b)
  );

  // A rejected zero candidate still consumes a step; the old sample stays parked
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      u0         <= '0;
      u1         <= '0;
      sample_cnt <= '0;
    end else begin
      if (out_valid && out_ready) begin
        sample_cnt <= sample_cnt + 32'd1;
      end
      if (seed_ld) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        out_valid <= cand_ok;
        if (cand_ok) begin
          u0 <= cand_u0;
          u1 <= cand_u1;
        end
      end
    end
  end

endmodule

// File: tb/tb_taus_urng.sv
// Self-checking bench for taus_urng against an arithmetic taus88 reference model.
module tb_taus_urng;

`ifdef URNG_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         seed_ld;
  logic [191:0] seed_in;
  logic         out_ready;
  logic         out_valid;
  logic [47:0]  u0;
  logic [15:0]  u1;
  logic [31:0]  sample_cnt;

  always #5 clk = ~clk;

  taus_urng dut (
    .clk        (clk),
    .rst        (rst),
    .seed_ld    (seed_ld),
    .seed_in    (seed_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .u0         (u0),
    .u1         (u1),
    .sample_cnt (sample_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: generator states {s0,s1,s2} and expected output register
  logic [95:0] ma, mb;
  logic        e_valid;
  logic [47:0] e_u0;
  logic [15:0] e_u1;
  logic [31:0] e_cnt;

  function automatic logic [31:0] mul_pow2(input logic [31:0] x, input int n);
    longint unsigned p;
    p = longint'(x) * (64'd2 ** n);
    return p[31:0];
  endfunction

  function automatic logic [31:0] div_pow2(input logic [31:0] x, input int n);
    return 32'(x / (32'd2 ** n));
  endfunction

  // Clear the low 'lc' bits, multiply by 2^a, xor with ((x*2^b) ^ x) / 2^c
  function automatic logic [31:0] comp(input logic [31:0] x, input int lc,
                                       input int a, input int b, input int c);
    logic [31:0] m;
    m = x - (x % (32'd2 ** lc));
    return mul_pow2(m, a) ^ div_pow2(mul_pow2(x, b) ^ x, c);
  endfunction

  function automatic logic [95:0] m_next(input logic [95:0] s);
    return {comp(s[95:64], 1, 12, 13, 19),
            comp(s[63:32], 3, 4, 2, 25),
            comp(s[31:0],  4, 17, 3, 11)};
  endfunction

  function automatic logic [31:0] m_word(input logic [95:0] s);
    return s[95:64] ^ s[63:32] ^ s[31:0];
  endfunction

  function automatic logic [95:0] m_fix(input logic [95:0] s);
    logic [31:0] a, b, c;
    a = s[95:64];
    b = s[63:32];
    c = s[31:0];
    if (a < 2)  a = a + 32'd2;
    if (b < 8)  b = b + 32'd8;
    if (c < 16) c = c + 32'd16;
    return {a, b, c};
  endfunction

  // Drive one cycle of stimulus and advance the model by the handshake rules
  task automatic drive_cycle(input logic rdy, input logic ld, input logic [191:0] sd);
    logic [31:0] wa, wb;
    out_ready = rdy;
    seed_ld   = ld;
    seed_in   = sd;
    @(posedge clk);
    if (e_valid && rdy) e_cnt = e_cnt + 32'd1;
    if (ld) begin
      ma      = m_fix(sd[191:96]);
      mb      = m_fix(sd[95:0]);
      e_valid = 1'b0;
    end else if (!e_valid || rdy) begin
      ma = m_next(ma);
      mb = m_next(mb);
      wa = m_word(ma);
      wb = m_word(mb);
      if (ZSKIP && {wa, wb[31:16]} == 48'd0) begin
        e_valid = 1'b0;
      end else begin
        e_valid = 1'b1;
        e_u0    = {wa, wb[31:16]};
        e_u1    = wb[15:0];
      end
    end
    @(negedge clk);
    seed_ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_ld = 1'b0; seed_in = '0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, u0, u1, sample_cnt} !== 97'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d: got v=%b u0=%h u1=%h cnt=%0d, want all zero",
                 i, out_valid, u0, u1, sample_cnt);
      end
    end
    ma = m_fix({3{32'd12345}});
    mb = m_fix({3{32'd987654321}});
    e_valid = 1'b0; e_u0 = '0; e_u1 = '0; e_cnt = '0;
    rst = 1'b0;
    drive_cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (out_valid !== 1'b1 || u0 !== e_u0 || u1 !== e_u1) begin
      n_fail++;
      $display("FAIL first_sample: got v=%b u0=%h u1=%h, want v=1 u0=%h u1=%h",
               out_valid, u0, u1, e_u0, e_u1);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 1000; i++) begin
      drive_cycle(1'b1, 1'b0, '0);
      n_checks++;
      if ({out_valid, u0, u1, sample_cnt} !== {e_valid, e_u0, e_u1, e_cnt}) begin
        n_fail++;
        $display("FAIL stream i=%0d: got v=%b u0=%h u1=%h cnt=%0d, want v=%b u0=%h u1=%h cnt=%0d",
                 i, out_valid, u0, u1, sample_cnt, e_valid, e_u0, e_u1, e_cnt);
      end
    end
    n_checks++;
    if (sample_cnt !== 32'd1000) begin
      n_fail++;
      $display("FAIL stream_count: got %0d, want 1000", sample_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [31:0] cnt_held;
    held     = {e_u0, e_u1};
    cnt_held = e_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, '0);
      n_checks++;
      if (out_valid !== 1'b1 || {u0, u1} !== held || sample_cnt !== cnt_held) begin
        n_fail++;
        $display("FAIL stall i=%0d: got v=%b u=%h cnt=%0d, want v=1 u=%h cnt=%0d",
                 i, out_valid, {u0, u1}, sample_cnt, held, cnt_held);
      end
    end
    for (int i = 0; i < 300; i++) begin
      drive_cycle((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, '0);
      n_checks++;
      if ({out_valid, u0, u1, sample_cnt} !== {e_valid, e_u0, e_u1, e_cnt}) begin
        n_fail++;
        $display("FAIL backpressure i=%0d: got v=%b u0=%h u1=%h cnt=%0d, want v=%b u0=%h u1=%h cnt=%0d",
                 i, out_valid, u0, u1, sample_cnt, e_valid, e_u0, e_u1, e_cnt);
      end
    end
  endtask

  task automatic test_seed_zero();
    logic [95:0] sa, sb;
    drive_cycle(1'b0, 1'b1, '0);
    sa = dut.u_core_a.state;
    sb = dut.u_core_b.state;
    n_checks++;
    if (sa !== {32'd2, 32'd8, 32'd16} || sb !== {32'd2, 32'd8, 32'd16} || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_zero_state: got A=%h B=%h v=%b, want A=B=%h v=0",
               sa, sb, out_valid, {32'd2, 32'd8, 32'd16});
    end
    drive_cycle(1'b1, 1'b0, '0);
    n_checks++;
    if ({out_valid, u0, u1, sample_cnt} !== {1'b1, e_u0, e_u1, e_cnt}) begin
      n_fail++;
      $display("FAIL seed_zero_first: got v=%b u0=%h u1=%h cnt=%0d, want v=1 u0=%h u1=%h cnt=%0d",
               out_valid, u0, u1, sample_cnt, e_u0, e_u1, e_cnt);
    end
  endtask

  task automatic test_seed_transfer();
    logic [191:0] sd;
    logic [31:0]  cnt_before;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) sd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      else sd = {32'($urandom_range(0, 20)), 32'($urandom_range(0, 20)), 32'($urandom_range(0, 20)),
                 32'($urandom_range(0, 20)), 32'($urandom_range(0, 20)), 32'($urandom_range(0, 20))};
      drive_cycle(1'b1, 1'b0, '0);
      cnt_before = e_cnt;
      drive_cycle(1'b1, 1'b1, sd);
      n_checks++;
      if (out_valid !== 1'b0 || sample_cnt !== cnt_before + 32'd1) begin
        n_fail++;
        $display("FAIL seed_xfer k=%0d: got v=%b cnt=%0d, want v=0 cnt=%0d",
                 k, out_valid, sample_cnt, cnt_before + 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
        drive_cycle(1'b1, 1'b0, '0);
        n_checks++;
        if ({out_valid, u0, u1, sample_cnt} !== {e_valid, e_u0, e_u1, e_cnt}) begin
          n_fail++;
          $display("FAIL seed_stream k=%0d i=%0d: got v=%b u0=%h u1=%h cnt=%0d, want v=%b u0=%h u1=%h cnt=%0d",
                   k, i, out_valid, u0, u1, sample_cnt, e_valid, e_u0, e_u1, e_cnt);
        end
      end
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 1'b0, '0);
    force dut.sample_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.sample_cnt;
    e_cnt = 32'hFFFF_FFFF;
    drive_cycle(1'b1, 1'b0, '0);
    n_checks++;
    if (sample_cnt !== 32'd0 || {u0, u1} !== {e_u0, e_u1}) begin
      n_fail++;
      $display("FAIL cnt_wrap: got cnt=%h u=%h, want cnt=0 u=%h", sample_cnt, {u0, u1}, {e_u0, e_u1});
    end
  endtask

  task automatic test_zero();
    logic [47:0] prev_u0;
    logic [15:0] prev_u1;
    drive_cycle(1'b1, 1'b0, '0);
    prev_u0 = e_u0;
    prev_u1 = e_u1;
    force dut.u_core_a.word_c = 32'd0;
    force dut.u_core_b.word_c = 32'd0;
    out_ready = 1'b1;
    @(posedge clk);
    if (e_valid) e_cnt = e_cnt + 32'd1;
    ma = m_next(ma);
    mb = m_next(mb);
    if (ZSKIP) begin
      e_valid = 1'b0;
    end else begin
      e_valid = 1'b1;
      e_u0    = '0;
      e_u1    = '0;
    end
    @(negedge clk);
    release dut.u_core_a.word_c;
    release dut.u_core_b.word_c;
    n_checks++;
    if ({out_valid, u0, u1, sample_cnt} !== {e_valid, e_u0, e_u1, e_cnt}) begin
      n_fail++;
      $display("FAIL zero_word: got v=%b u0=%h u1=%h cnt=%0d, want v=%b u0=%h u1=%h cnt=%0d (prev u0=%h u1=%h)",
               out_valid, u0, u1, sample_cnt, e_valid, e_u0, e_u1, e_cnt, prev_u0, prev_u1);
    end
    drive_cycle(1'b1, 1'b0, '0);
    n_checks++;
    if ({out_valid, u0, u1, sample_cnt} !== {1'b1, e_u0, e_u1, e_cnt}) begin
      n_fail++;
      $display("FAIL zero_next: got v=%b u0=%h u1=%h cnt=%0d, want v=1 u0=%h u1=%h cnt=%0d",
               out_valid, u0, u1, sample_cnt, e_u0, e_u1, e_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_seed_zero();
    test_seed_transfer();
    test_wrap();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, want completion before 2000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/taus_urng.md
Name: taus_urng

Overview:
- Uniform random number source for the AWGN chain.
- Two independent combined Tausworthe (taus88) generators produce 64 fresh bits per step.
- The 64 bits are split into u0 (48 b, feeds the logarithm stage) and u1 (16 b, feeds the sin/cos stage).
- Output is registered behind a valid/ready handshake, so the log stage and the downstream pipeline can stall the source without losing or repeating samples.

Parameters:
- SEED_A0, 32'd12345, reset seed of generator A component 0
- SEED_A1, 32'd12345, reset seed of generator A component 1
- SEED_A2, 32'd12345, reset seed of generator A component 2
- SEED_B0, 32'd987654321, reset seed of generator B component 0
- SEED_B1, 32'd987654321, reset seed of generator B component 1
- SEED_B2, 32'd987654321, reset seed of generator B component 2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- seed_ld  in  1  load seed_in into both generators this cycle
- seed_in  in  192  {A0,A1,A2,B0,B1,B2}, A0 in bits 191:160
- out_ready  in  1  consumer accepts u0/u1 this cycle
- out_valid  out  1  u0/u1 hold a valid sample
- u0  out  48  uniform sample to log stage, unsigned fraction, 0.u0
- u1  out  16  uniform sample to sin/cos stage, unsigned fraction
- sample_cnt  out  32  number of completed transfers, wraps at 2^32

Behaviour:
- Reset (rst=1 at edge): state <= parameter seeds after seed fix-up; out_valid=0; u0=0; u1=0; sample_cnt=0. Reset overrides seed_ld and the handshake.
- Component step (s0,s1,s2), per standard taus88, all 32-bit, logical shifts:
  - s0' = ((s0 & 32'hFFFFFFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19)
  - s1' = ((s1 & 32'hFFFFFFF8) << 4) ^ (((s1 << 2) ^ s1) >> 25)
  - s2' = ((s2 & 32'hFFFFFFF0) << 17) ^ (((s2 << 3) ^ s2) >> 11)
  - Generator word = s0' ^ s1' ^ s2'.
- Mapping: a = word of A, b = word of B; u0 = {a, b[31:16]}; u1 = b[15:0].
- Seed fix-up on reset and on seed_ld: if s0<2, set bit 1; if s1<8, set bit 3; if s2<16, set bit 4. Applied per component, both generators.
- adv = !out_valid || out_ready. When adv and not seed_ld: generators step, u0/u1 load the new words, out_valid <= 1.
- Latency: first out_valid=1 one cycle after rst falls; then one sample per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, u0/u1/state are frozen; no sample is dropped or duplicated.
- Transfer = out_valid && out_ready at an edge; sample_cnt increments by 1, wrapping 32'hFFFFFFFF to 0.
- seed_ld=1: state <= fixed-up seed_in; out_valid <= 0; u0/u1 hold their old value. A transfer in the same cycle still counts. The generator does not step that cycle; the next valid sample is the first step from the new seed, one cycle later.

Optional Feature:
- Macro URNG_ZERO_SKIP_EN.
- Defined: a candidate with u0==48'd0 is never presented. The generator steps again on the next cycle with out_valid kept 0, so the log stage never sees ln(0).
- Undefined: zero samples pass through unchanged, and the log stage's zero clamp handles them.

Decomposition:
- Package urng_pkg: TAUS_W=32, U0_W=48, U1_W=16, the three component masks and shift constants, the default seed constants, and a taus88_step function usable by the bench model.
- One sub-module, taus88_core: 96-bit state, load/step/hold controls, seed fix-up, 32-bit word output. It is instantiated twice (A, B).

Test Plan:
- Reset with default params, out_ready=1 -> out_valid=0, u0=0, sample_cnt=0 during reset; out_valid=1 on the first cycle after rst falls; first 1000 u0/u1 match the C taus88 model bit-exact; sample_cnt=1000.
- out_ready=0 for 5 cycles mid-stream -> u0/u1 stable for all 5 cycles, no count change; resuming yields the next model value, with no gap and no repeat.
- seed_ld with all components = 0 -> internal state A/B = {2,8,16}; next valid u0/u1 equals the model stepped from {2,8,16}.
- seed_ld asserted in the same cycle as a transfer -> sample_cnt increments once, out_valid=0 next cycle, then new-seed stream.
- sample_cnt forced to 32'hFFFFFFFF, one transfer -> sample_cnt=0.
- With URNG_ZERO_SKIP_EN, core word forced to 0 for one step -> that sample is never valid; the next nonzero sample appears one cycle later. Without the macro -> u0=0 is presented with out_valid=1.
